// File: rtl/vga_pkg.sv
// Timing constants and shared types for the 1024x768@60Hz VGA timing generator.
// All constants are typed to the counter width so comparisons stay width-matched.
package vga_pkg;

  localparam int unsigned CNT_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HOR_TOTAL_TIME  = 11'd1344;
  localparam cnt_t HOR_BLANK_START = 11'd1024;
  localparam cnt_t HOR_SYNC_START  = 11'd1048;
  localparam cnt_t HOR_SYNC_TIME   = 11'd136;

  localparam cnt_t VER_TOTAL_TIME  = 11'd806;
  localparam cnt_t VER_BLANK_START = 11'd768;
  localparam cnt_t VER_SYNC_START  = 11'd771;
  localparam cnt_t VER_SYNC_TIME   = 11'd6;

  // First count past the sync pulse.
  localparam cnt_t HOR_SYNC_END = HOR_SYNC_START + HOR_SYNC_TIME;
  localparam cnt_t VER_SYNC_END = VER_SYNC_START + VER_SYNC_TIME;

endpackage

// File: rtl/vga_if.sv
// Video bundle passed down the draw pipeline: pixel position, sync/blank strobes and colour.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );

  modport in (
    input hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );

endinterface

// File: rtl/vga_timing_counter.sv
// Mod-N counter exposing its next-state value and a wrap strobe for cascading.
// Any out-of-range count returns to zero on the following edge.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter cnt_t N = HOR_TOTAL_TIME
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output cnt_t next_o,
  output logic wrap_o
);

  localparam cnt_t Last = N - cnt_t'(1);

  cnt_t count_q, count_d;

  always_comb begin
    wrap_o = en_i && (count_q >= Last);
    if (count_q > Last) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == Last) ? '0 : count_q + cnt_t'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign next_o = count_d;

endmodule

// File: rtl/vga_timing.sv
// VGA 1024x768@60Hz timing generator: cascaded pixel/line counters with registered strobes.
// Strobes decode the counters' next-state values so they align with the registered counts.
module vga_timing
  import vga_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  vga_if.out    vga_out
);

  cnt_t h_next, v_next;
  logic h_wrap;
  logic v_wrap;
  logic hblnk_d, hsync_d, vblnk_d, vsync_d;

  vga_timing_counter #(
    .N (HOR_TOTAL_TIME)
  ) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .next_o (h_next),
    .wrap_o (h_wrap)
  );

  // Vertical advances once per line, on the horizontal wrap.
  vga_timing_counter #(
    .N (VER_TOTAL_TIME)
  ) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (h_wrap),
    .next_o (v_next),
    .wrap_o (v_wrap)
  );

  always_comb begin
    hblnk_d = (h_next >= HOR_BLANK_START);
    hsync_d = (h_next >= HOR_SYNC_START) && (h_next < HOR_SYNC_END);
    vblnk_d = (v_next >= VER_BLANK_START);
    vsync_d = (v_next >= VER_SYNC_START) && (v_next < VER_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hblnk  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= h_next;
      vga_out.vcount <= v_next;
      vga_out.hblnk  <= hblnk_d;
      vga_out.hsync  <= hsync_d;
      vga_out.vblnk  <= vblnk_d;
      vga_out.vsync  <= vsync_d;
      vga_out.rgb    <= '0;
    end
  end

  // Frame wrap is implied by the counters; nothing downstream consumes it here.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a reference model fills a scoreboard every clock, a monitor
// compares the bundle each cycle, and directed sequences probe wraps and strobe edges.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_if vga ();

  vga_timing dut (
    .clk     (clk),
    .rst     (rst),
    .vga_out (vga)
  );

  always #8 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Vertical preload requests: stimulus bumps dep_seq, the model consumes it.
  int dep_seq  = 0;
  int dep_done = 0;
  int dep_val  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pushes the expected bundle for every clock edge.
  initial begin
    int   mh;
    int   mv;
    exp_t e;
    mh = 0;
    mv = 0;
    forever begin
      @(posedge clk);
      if (dep_seq != dep_done) begin
        mv       = dep_val;
        dep_done = dep_seq;
      end
      if (rst) begin
        mh = 0;
        mv = 0;
      end else if (mh == 1343) begin
        mh = 0;
        mv = (mv == 805) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e.h   = 11'(mh);
      e.v   = 11'(mv);
      e.hb  = (mh >= 1024);
      e.hs  = (mh >= 1048) && (mh <= 1183);
      e.vb  = (mv >= 768);
      e.vs  = (mv >= 771) && (mv <= 776);
      e.rgb = 12'h000;
      sbq.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a bundle; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        check("sb_hcount", 32'(vga.hcount), 32'(e.h));
        check("sb_vcount", 32'(vga.vcount), 32'(e.v));
        check("sb_strobes", {28'd0, vga.hsync, vga.hblnk, vga.vsync, vga.vblnk},
              {28'd0, e.hs, e.hb, e.vs, e.vb});
        check("sb_rgb", 32'(vga.rgb), 32'd0);
        check("range_h", 32'(vga.hcount < 11'd1344), 32'd1);
        check("range_v", 32'(vga.vcount < 11'd806), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deposit_v(input int v);
    @(negedge clk);
    dep_val = v;
    dep_seq++;
    force dut.u_vcnt.count_q = 11'(v);
    #1;
    release dut.u_vcnt.count_q;
  endtask

  // Bounded wait for a given position; v < 0 matches any line.
  task automatic wait_hv(input int h, input int v, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (vga.hcount == 11'(h) && (v < 0 || vga.vcount == 11'(v))) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    int first;
    int last;

    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_hcount", 32'(vga.hcount), 32'd0);
    check("rst_vcount", 32'(vga.vcount), 32'd0);
    check("rst_strobes", {28'd0, vga.hsync, vga.hblnk, vga.vsync, vga.vblnk}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_hcount", 32'(vga.hcount), 32'd1);
    check("first_vcount", 32'(vga.vcount), 32'd0);

    // Line wrap.
    wait_hv(1343, 0, 3000, "line_end");
    check("line_end_hblnk", 32'(vga.hblnk), 32'd1);
    check("line_end_hsync", 32'(vga.hsync), 32'd0);
    tick();
    check("wrap_hcount", 32'(vga.hcount), 32'd0);
    check("wrap_vcount", 32'(vga.vcount), 32'd1);

    // Horizontal strobe edges and hsync width.
    wait_hv(1023, -1, 3000, "hblnk_pre");
    check("hblnk_1023", 32'(vga.hblnk), 32'd0);
    tick();
    check("hblnk_1024", 32'(vga.hblnk), 32'd1);
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 400 && vga.hcount != 11'd1343; i++) begin
      tick();
      if (vga.hsync) begin
        cnt++;
        if (first < 0) first = int'(vga.hcount);
        last = int'(vga.hcount);
      end
    end
    check("hsync_width", 32'(cnt), 32'd136);
    check("hsync_first", 32'(first), 32'd1048);
    check("hsync_last", 32'(last), 32'd1183);

    // Vertical strobe edges and vsync width, starting just above the blank region.
    deposit_v(766);
    wait_hv(1343, 767, 3000, "vblnk_pre");
    check("vblnk_767", 32'(vga.vblnk), 32'd0);
    tick();
    check("vblnk_768", 32'(vga.vblnk), 32'd1);
    check("vblnk_768_h", 32'(vga.hcount), 32'd0);
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 20000 && vga.vcount != 11'd778; i++) begin
      tick();
      if (vga.vsync) begin
        cnt++;
        if (first < 0) first = int'(vga.vcount);
        last = int'(vga.vcount);
      end
    end
    check("vsync_width", 32'(cnt), 32'd8064);
    check("vsync_first", 32'(first), 32'd771);
    check("vsync_last", 32'(last), 32'd776);

    // Frame wrap.
    deposit_v(805);
    wait_hv(1343, 805, 3000, "frame_end");
    check("frame_end_vblnk", 32'(vga.vblnk), 32'd1);
    check("frame_end_vsync", 32'(vga.vsync), 32'd0);
    tick();
    check("fwrap_hcount", 32'(vga.hcount), 32'd0);
    check("fwrap_vcount", 32'(vga.vcount), 32'd0);
    check("fwrap_vblnk", 32'(vga.vblnk), 32'd0);
    check("fwrap_vsync", 32'(vga.vsync), 32'd0);

    // Mid-frame reset pulse.
    deposit_v(400);
    wait_hv(500, 400, 3000, "mid_pos");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_hcount", 32'(vga.hcount), 32'd0);
    check("mid_rst_vcount", 32'(vga.vcount), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_post_hcount", 32'(vga.hcount), 32'd1);
    check("mid_post_vcount", 32'(vga.vcount), 32'd0);
    repeat (1500) tick();
    check("mid_follow_vcount", 32'(vga.vcount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
